multicycle_control: RTL and testbench

Main control FSM for the multicycle MIPS32 datapath. Sequences instruction fetch, decode, execute, memory access and write-back over multiple cycles, driving the datapath mux selects, the register-file and memory enables, and the 2-bit ALU op consumed by `alu_control`. Consumes `alu_control`'s `jr` flag to redirect the PC. Supports stalling memory through a ready handshake.

---
 rtl/multicycle_control_pkg.sv | 48 ++++
 rtl/multicycle_control_opcode_decode.sv | 26 ++
 rtl/multicycle_control.sv | 151 +++++++++++++++
 tb/tb_multicycle_control.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS32 control path: 4-bit state
// encodings, opcodes, and the alu_op / alu_src_b / pc_source encodings used
// by the control FSM, alu_control and the datapath.
package multicycle_control_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;

    // FSM state encodings
    localparam logic [3:0] ST_FETCH     = 4'd0;
    localparam logic [3:0] ST_DECODE    = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
    localparam logic [3:0] ST_MEM_READ  = 4'd3;
    localparam logic [3:0] ST_MEM_WB    = 4'd4;
    localparam logic [3:0] ST_MEM_WRITE = 4'd5;
    localparam logic [3:0] ST_EXECUTE   = 4'd6;
    localparam logic [3:0] ST_ALU_WB    = 4'd7;
    localparam logic [3:0] ST_BRANCH    = 4'd8;
    localparam logic [3:0] ST_JUMP      = 4'd9;
    localparam logic [3:0] ST_ADDI_EX   = 4'd10;
    localparam logic [3:0] ST_ADDI_WB   = 4'd11;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation class handed to alu_control
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] ALUB_REG_B   = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP    = 2'b10;
    localparam logic [1:0] PC_SRC_REG_A   = 2'b11;

endpackage

// File: rtl/multicycle_control_opcode_decode.sv
// Combinational opcode dispatch for the DECODE state.
// Ports: opcode (IR[31:26]) in; next_state (state to enter after DECODE) and
// illegal (opcode not supported) out.
module opcode_decode
    import multicycle_control_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output logic [STATE_W-1:0]  next_state,
    output logic                illegal
);

    // Unsupported opcodes fall back to FETCH and flag illegal.
    always_comb begin
        next_state = ST_FETCH;
        illegal    = 1'b0;
        case (opcode)
            OP_RTYPE:     next_state = ST_EXECUTE;
            OP_LW, OP_SW: next_state = ST_MEM_ADDR;
            OP_BEQ:       next_state = ST_BRANCH;
            OP_J:         next_state = ST_JUMP;
            OP_ADDI:      next_state = ST_ADDI_EX;
            default:      illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS32 datapath.
// Ports: clk, rst (sync, active-high); opcode, jr (from alu_control),
// mem_ready (memory handshake) in. Datapath controls (pc_write,
// pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
// reg_write, alu_src_a, alu_src_b, alu_op, pc_source), illegal_op pulse and
// debug state out. Only state is registered; controls decode from it.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                jr,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [STATE_W-1:0] decode_next;
    logic               decode_illegal;

    opcode_decode u_opcode_decode (
        .opcode     (opcode),
        .next_state (decode_next),
        .illegal    (decode_illegal)
    );

    // State register; reset wins over any pending transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Next-state and control decode.
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG_B;
        alu_op        = ALU_OP_ADD;
        pc_source     = PC_SRC_ALU;
        illegal_op    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // IR load and PC+4 commit only once memory returns the word.
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // Precompute branch target into ALUOut.
                alu_src_b  = ALUB_IMM_SH2;
                illegal_op = decode_illegal;
                state_d    = decode_next;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                state_d   = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_d = ST_FETCH;
            end
            ST_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
                // jr redirects the PC here and skips write-back.
                if (jr) begin
                    pc_write  = 1'b1;
                    pc_source = PC_SRC_REG_A;
                    state_d   = ST_FETCH;
                end else begin
                    state_d   = ST_ALU_WB;
                end
            end
            ST_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALU_OUT;
                state_d       = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
                state_d   = ST_FETCH;
            end
            ST_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                state_d   = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle
// by cycle and compares state plus the packed control vector.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       jr;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .jr            (jr),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Field order: pw pwc iod mr mw irw m2r rd rw asa | asb | aop | psrc | ill
    logic [16:0] ctl;
    assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_source, illegal_op};

    localparam logic [16:0] E_FETCH_W   = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_FETCH_R   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_DECODE    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] E_DEC_ILL   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] E_MEM_ADDR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] E_MEM_READ  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_MEM_WB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] E_MEM_WRITE = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_EXEC      = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] E_EXEC_JR   = 17'b1_0_0_0_0_0_0_0_0_1_00_10_11_0;
    localparam logic [16:0] E_ALU_WB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] E_BRANCH    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] E_JUMP      = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] E_ADDI_EX   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] E_ADDI_WB   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp_v);
        end
    endtask

    // Let the current inputs settle, check this cycle, then advance one edge.
    task automatic cyc(input string tag, input logic [3:0] es, input logic [16:0] ec);
        #1;
        chk({tag, ".state"}, 20'(state), 20'(es));
        chk({tag, ".ctl"},   20'(ctl),   20'(ec));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 6'b000000;
        jr        = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("reset", ST_FETCH, E_FETCH_W);

        // Fetch stall: holds one extra cycle
        mem_ready = 1'b0;
        cyc("fetch_wait", ST_FETCH, E_FETCH_W);

        // lw, memory always ready: 5 cycles
        mem_ready = 1'b1; opcode = OP_LW;
        cyc("lw.c1", ST_FETCH,    E_FETCH_R);
        cyc("lw.c2", ST_DECODE,   E_DECODE);
        cyc("lw.c3", ST_MEM_ADDR, E_MEM_ADDR);
        cyc("lw.c4", ST_MEM_READ, E_MEM_READ);
        cyc("lw.c5", ST_MEM_WB,   E_MEM_WB);

        // sw with 3 wait cycles in MEM_WRITE: 7 cycles
        opcode = OP_SW;
        cyc("sw.c1", ST_FETCH,    E_FETCH_R);
        cyc("sw.c2", ST_DECODE,   E_DECODE);
        cyc("sw.c3", ST_MEM_ADDR, E_MEM_ADDR);
        mem_ready = 1'b0;
        cyc("sw.w1", ST_MEM_WRITE, E_MEM_WRITE);
        cyc("sw.w2", ST_MEM_WRITE, E_MEM_WRITE);
        cyc("sw.w3", ST_MEM_WRITE, E_MEM_WRITE);
        mem_ready = 1'b1;
        cyc("sw.c7", ST_MEM_WRITE, E_MEM_WRITE);

        // R-type, jr=0: 4 cycles
        opcode = OP_RTYPE; jr = 1'b0;
        cyc("r.c1", ST_FETCH,   E_FETCH_R);
        cyc("r.c2", ST_DECODE,  E_DECODE);
        cyc("r.c3", ST_EXECUTE, E_EXEC);
        cyc("r.c4", ST_ALU_WB,  E_ALU_WB);

        // jr: 3 cycles, ALU_WB skipped; jr ignored outside EXECUTE
        jr = 1'b1;
        cyc("jr.c1", ST_FETCH,   E_FETCH_R);
        cyc("jr.c2", ST_DECODE,  E_DECODE);
        cyc("jr.c3", ST_EXECUTE, E_EXEC_JR);
        jr = 1'b0;

        // beq: 3 cycles; mem_ready low in DECODE/BRANCH is ignored
        opcode = OP_BEQ;
        cyc("beq.c1", ST_FETCH,  E_FETCH_R);
        mem_ready = 1'b0;
        cyc("beq.c2", ST_DECODE, E_DECODE);
        cyc("beq.c3", ST_BRANCH, E_BRANCH);
        mem_ready = 1'b1;

        // j: 3 cycles
        opcode = OP_J;
        cyc("j.c1", ST_FETCH,  E_FETCH_R);
        cyc("j.c2", ST_DECODE, E_DECODE);
        cyc("j.c3", ST_JUMP,   E_JUMP);

        // addi: 4 cycles
        opcode = OP_ADDI;
        cyc("addi.c1", ST_FETCH,   E_FETCH_R);
        cyc("addi.c2", ST_DECODE,  E_DECODE);
        cyc("addi.c3", ST_ADDI_EX, E_ADDI_EX);
        cyc("addi.c4", ST_ADDI_WB, E_ADDI_WB);

        // Illegal opcode: pulse in DECODE only, back to FETCH
        opcode = 6'b111111;
        cyc("ill.c1", ST_FETCH,  E_FETCH_R);
        cyc("ill.c2", ST_DECODE, E_DEC_ILL);
        mem_ready = 1'b0;
        cyc("ill.after", ST_FETCH, E_FETCH_W);

        // Reset in MEM_READ with mem_ready pending: must land in FETCH
        mem_ready = 1'b1; opcode = OP_LW;
        cyc("rlw.c1", ST_FETCH,    E_FETCH_R);
        cyc("rlw.c2", ST_DECODE,   E_DECODE);
        cyc("rlw.c3", ST_MEM_ADDR, E_MEM_ADDR);
        rst = 1'b1;
        cyc("rlw.c4", ST_MEM_READ, E_MEM_READ);
        rst = 1'b0; mem_ready = 1'b0;
        cyc("rst_mid", ST_FETCH, E_FETCH_W);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
